// File: rtl/framebuffer_dbuf.sv
// framebuffer_dbuf
// Double-buffered pixel frame store. The rasteriser writes the back buffer while
// scan-out reads the front buffer. A flip request is held until the next frame
// boundary, after which the buffers swap and the new back buffer is wiped to zero
// so the rasteriser always starts from a blank canvas.
module framebuffer_dbuf #(
    parameter  int WIDTH  = 640,
    parameter  int HEIGHT = 480,
    parameter  int PIX_W  = 1,
    localparam int DEPTH  = WIDTH * HEIGHT,
    // One spare code above DEPTH-1 so an out-of-range address is always
    // representable on the ports, even when DEPTH is a power of two.
    localparam int ADDR_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [PIX_W-1:0]  wr_data,
    output logic              wr_ready,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [PIX_W-1:0]  rd_data,
    output logic              rd_valid,
    input  logic              flip_req,
    input  logic              frame_end,
    output logic              flip_done,
    output logic              front_sel
);

    // Width of the physical RAM index (the address minus its spare range bit).
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;

    logic [1:0]       state;
    logic [IDX_W-1:0] cnt;
    logic             pending;

    logic             swap;
    logic             cnt_last;
    logic             wr_accept;
    logic             rd_in_range;
    logic [IDX_W-1:0] rd_idx;

    logic             we0;
    logic             we1;
    logic [IDX_W-1:0] waddr;
    logic [PIX_W-1:0] wdata;

    logic [PIX_W-1:0] mem0 [DEPTH];
    logic [PIX_W-1:0] mem1 [DEPTH];

    // The writer is only admitted while idle; INIT and CLEAR own the write ports.
    assign wr_ready    = (state == ST_IDLE);
    assign wr_accept   = wr_en && wr_ready && (wr_addr < DEPTH_A);
    assign cnt_last    = (cnt == LAST_IDX);
    // A flip_req arriving together with frame_end counts as already pending.
    assign swap        = (state == ST_IDLE) && frame_end && (pending || flip_req);
    assign rd_in_range = (rd_addr < DEPTH_A);
    assign rd_idx      = rd_addr[IDX_W-1:0];

    // Sequencer: INIT wipe of both buffers, idle service, post-swap wipe of the back buffer.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= ST_INIT;
            cnt       <= '0;
            front_sel <= 1'b0;
            flip_done <= 1'b0;
        end else begin
            flip_done <= 1'b0;
            case (state)
                ST_INIT: begin
                    if (cnt_last) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (swap) begin
                        front_sel <= ~front_sel;
                        flip_done <= 1'b1;
                        cnt       <= '0;
                        state     <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    if (cnt_last) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= ST_INIT;
                end
            endcase
        end
    end

    // Flip request latch: repeated requests collapse into one, cleared by the swap itself.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pending <= 1'b0;
        end else if (swap) begin
            pending <= 1'b0;
        end else if (flip_req) begin
            pending <= 1'b1;
        end
    end

    // Write-port mux: clear engine has the ports in INIT/CLEAR, the rasteriser in IDLE.
    always_comb begin
        we0   = 1'b0;
        we1   = 1'b0;
        waddr = wr_addr[IDX_W-1:0];
        wdata = wr_data;
        case (state)
            ST_INIT: begin
                we0   = 1'b1;
                we1   = 1'b1;
                waddr = cnt;
                wdata = '0;
            end
            ST_CLEAR: begin
                waddr = cnt;
                wdata = '0;
                if (front_sel) begin
                    we0 = 1'b1;
                end else begin
                    we1 = 1'b1;
                end
            end
            default: begin
                if (wr_accept) begin
                    if (front_sel) begin
                        we0 = 1'b1;
                    end else begin
                        we1 = 1'b1;
                    end
                end
            end
        endcase
    end

    // Buffer 0 storage, single write port, contents not reset.
    always_ff @(posedge clk) begin
        if (we0) begin
            mem0[waddr] <= wdata;
        end
    end

    // Buffer 1 storage, single write port, contents not reset.
    always_ff @(posedge clk) begin
        if (we1) begin
            mem1[waddr] <= wdata;
        end
    end

    // Registered front-buffer read; holds the last pixel when no read is issued.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                if (!rd_in_range) begin
                    rd_data <= '0;
                end else if (front_sel) begin
                    rd_data <= mem1[rd_idx];
                end else begin
                    rd_data <= mem0[rd_idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_framebuffer_dbuf.sv
// tb_framebuffer_dbuf
// Directed bench for the double-buffered frame store with a 4x2, 4-bit-pixel
// geometry. Reads push their expected pixel into a queue; a monitor pops and
// compares whenever rd_valid is presented.
module tb_framebuffer_dbuf;

    localparam int WIDTH  = 4;
    localparam int HEIGHT = 2;
    localparam int PIX_W  = 4;
    localparam int ADDR_W = 4;

    logic              clk;
    logic              n_rst;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [PIX_W-1:0]  wr_data;
    logic              wr_ready;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [PIX_W-1:0]  rd_data;
    logic              rd_valid;
    logic              flip_req;
    logic              frame_end;
    logic              flip_done;
    logic              front_sel;

    int n_checks = 0;
    int n_pass   = 0;
    int flip_cnt = 0;
    logic [PIX_W-1:0] exp_q [$];

    framebuffer_dbuf #(
        .WIDTH (WIDTH),
        .HEIGHT(HEIGHT),
        .PIX_W (PIX_W)
    ) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .flip_req (flip_req),
        .frame_end(frame_end),
        .flip_done(flip_done),
        .front_sel(front_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: count flip_done pulses and score every presented read.
    always @(negedge clk) begin
        if (flip_done === 1'b1) begin
            flip_cnt++;
        end
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL rd_unexpected: rd_valid=1 rd_data=%0h, expected no read outstanding", rd_data);
            end else begin
                check("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, input logic [PIX_W-1:0] e);
        rd_en   = 1'b1;
        rd_addr = a;
        exp_q.push_back(e);
        tick();
        rd_en = 1'b0;
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [PIX_W-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pulse(input logic fr, input logic fe);
        flip_req  = fr;
        frame_end = fe;
        tick();
        flip_req  = 1'b0;
        frame_end = 1'b0;
    endtask

    // Counts clock edges (starting from 'start') until wr_ready rises, bounded.
    task automatic wait_ready(input string name, input int start, input int exp);
        int n;
        n = start;
        while (wr_ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check(name, n, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_rst     = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_en     = 1'b0;
        rd_addr   = '0;
        flip_req  = 1'b0;
        frame_end = 1'b0;
        repeat (3) tick();

        // reset values
        check("rst_wr_ready", 32'(wr_ready), 0);
        check("rst_front_sel", 32'(front_sel), 0);
        check("rst_rd_valid", 32'(rd_valid), 0);
        check("rst_rd_data", 32'(rd_data), 0);
        check("rst_flip_done", 32'(flip_done), 0);

        // 1: INIT length and blank buffer
        n_rst = 1'b1;
        wait_ready("init_len", 0, 8);
        for (int a = 0; a < 8; a++) do_read(ADDR_W'(a), 4'h0);
        check("t1_front_sel", 32'(front_sel), 0);

        // 2: write back buffer, flip, read it from the front
        do_write(4'd3, 4'hA);
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        check("t2_front_sel", 32'(front_sel), 1);
        check("t2_clear_busy", 32'(wr_ready), 0);
        do_read(4'd3, 4'hA);
        wait_ready("t2_clear_len", 1, 8);
        check("t2_flip_cnt", flip_cnt, 1);

        // 3: flip_req with frame_end together; old front was cleared
        do_write(4'd5, 4'h7);
        pulse(1'b1, 1'b1);
        check("t3_front_sel", 32'(front_sel), 0);
        do_read(4'd3, 4'h0);
        do_read(4'd5, 4'h7);
        wait_ready("t3_clear_len", 2, 8);
        check("t3_flip_cnt", flip_cnt, 2);

        // 4: frame_end without request; frame_end ignored in CLEAR
        pulse(1'b0, 1'b1);
        tick();
        check("t4_noflip_front", 32'(front_sel), 0);
        check("t4_noflip_ready", 32'(wr_ready), 1);
        check("t4_noflip_cnt", flip_cnt, 2);
        pulse(1'b1, 1'b1);
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        check("t4_clear_front", 32'(front_sel), 1);
        wait_ready("t4_clear_len", 2, 8);
        check("t4_no_swap_in_clear", 32'(front_sel), 1);
        check("t4_flip_cnt_a", flip_cnt, 3);
        pulse(1'b0, 1'b1);
        check("t4_pending_swap", 32'(front_sel), 0);
        wait_ready("t4_clear_len2", 0, 8);
        check("t4_flip_cnt_b", flip_cnt, 4);

        // 5: out-of-range write/read, write dropped while not ready
        do_write(4'd1, 4'hC);
        do_write(4'd9, 4'hF);
        pulse(1'b1, 1'b1);
        do_read(4'd1, 4'hC);
        do_read(4'd9, 4'h0);
        tick();
        tick();
        do_write(4'd0, 4'h5);
        wait_ready("t5_clear_len", 5, 8);
        pulse(1'b1, 1'b1);
        check("t5_front_sel", 32'(front_sel), 0);
        do_read(4'd0, 4'h0);
        wait_ready("t5_clear_len2", 1, 8);
        check("t5_flip_cnt", flip_cnt, 6);

        // 6: reset in the middle of CLEAR
        do_write(4'd6, 4'h9);
        pulse(1'b1, 1'b1);
        do_read(4'd6, 4'h9);
        pulse(1'b1, 1'b0);
        tick();
        check("t6_rd_hold", 32'(rd_data), 32'h9);
        tick();
        n_rst = 1'b0;
        #1;
        check("t6_rst_front_sel", 32'(front_sel), 0);
        check("t6_rst_wr_ready", 32'(wr_ready), 0);
        check("t6_rst_rd_data", 32'(rd_data), 0);
        check("t6_rst_rd_valid", 32'(rd_valid), 0);
        check("t6_rst_flip_done", 32'(flip_done), 0);
        tick();
        n_rst = 1'b1;
        wait_ready("t6_reinit_len", 0, 8);
        check("t6_front_sel", 32'(front_sel), 0);
        check("t6_flip_cnt", flip_cnt, 7);
        pulse(1'b0, 1'b1);
        tick();
        check("t6_pending_cleared", 32'(front_sel), 0);
        check("t6_flip_cnt_b", flip_cnt, 7);
        do_read(4'd6, 4'h0);
        do_read(4'd1, 4'h0);
        tick();
        tick();
        check("rd_outstanding", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
